data_in_selector: RTL and testbench
===================================

DATA_IN_SELECTOR -- requirements
Module: data_in_selector

Interface
REQ-001 Parameter NUM_SRC, default 4: number of input stream sources (2..16).
REQ-002 Parameter DATA_W, default 32: signed sample width of every source and of the output.
REQ-003 Parameter SEL_W, default 2: source-select width; NUM_SRC SHALL be at most 2^SEL_W.
REQ-004 Parameter FRAME_W, default 32: width of frame length and sample counter.
REQ-005 clk  in  1  single clock; all logic SHALL be on its rising edge.
REQ-006 reset  in  1  synchronous, active-high reset.
REQ-007 enable  in  1  when low, input samples SHALL be ignored; FSM state is held.
REQ-008 start  in  1  single-cycle pulse that begins a frame.
REQ-009 sel  in  SEL_W  source index, latched at start.
REQ-010 dec_log2  in  5  decimation exponent, latched at start; N = 2^min(dec_log2,16).
REQ-011 frame_len  in  FRAME_W  output samples per frame, latched at start; 0 = continuous.
REQ-012 sync_mode  in  1  latched at start; 1 = wait for a rising edge of the selected sync bit before accepting samples.
REQ-013 src_data  in  NUM_SRC*DATA_W  packed source samples; source k occupies bits [k*DATA_W +: DATA_W].
REQ-014 src_valid  in  NUM_SRC  per-source sample strobes.
REQ-015 src_sync  in  NUM_SRC  per-source sync/zero-cross levels.
REQ-016 data_out  out  DATA_W  decimated sample, held between strobes.
REQ-017 data_out_valid  out  1  single-cycle strobe for data_out.
REQ-018 busy  out  1  high in ARMED and RUN.
REQ-019 done  out  1  single-cycle pulse at frame end.
REQ-020 sample_count  out  FRAME_W  output samples emitted in the current frame.

Function
REQ-021 FSM states: IDLE, ARMED, RUN, DONE.
REQ-022 IDLE: on start, latch sel/dec_log2/frame_len/sync_mode, clear sample_count and the decimation counter, go to ARMED if sync_mode else RUN.
REQ-023 ARMED: on rising edge (sync & ~sync_q) of src_sync[sel_latched] with enable high, go to RUN; a valid sample in that same cycle SHALL be accepted as the first sample.
REQ-024 sync_q SHALL register src_sync[sel_latched] every cycle, so a sync held high at start is not an edge.
REQ-025 RUN: a sample is accepted when enable and src_valid[sel_latched] are both high; the other sources' strobes are ignored.
REQ-026 The decimation counter SHALL count accepted samples 0..N-1; on the Nth, it wraps to 0 and one output is produced.
REQ-027 data_out and data_out_valid SHALL be registered one cycle after the cycle accepting the Nth sample.
REQ-028 sample_count SHALL increment in the same cycle as data_out_valid.
REQ-029 With frame_len != 0, the output making sample_count equal frame_len SHALL move the FSM to DONE the next cycle; further samples are ignored.
REQ-030 DONE SHALL last one cycle, assert done, and return to IDLE; start in DONE is ignored.
REQ-031 start while busy SHALL be ignored; the latched parameters SHALL NOT change mid-frame.
REQ-032 With frame_len = 0, RUN SHALL continue until reset, and sample_count SHALL wrap modulo 2^FRAME_W.
REQ-033 sel >= NUM_SRC SHALL select source 0.
REQ-034 dec_log2 > 16 SHALL be treated as 16.

Reset
REQ-035 On reset: state IDLE; data_out 0; data_out_valid, busy, done 0; sample_count 0; accumulator and decimation counter 0; sync_q 1.
REQ-036 Reset mid-frame SHALL abandon the frame without asserting done.

Configuration
REQ-037 Macro DATA_IN_SELECTOR_AVG_EN defined: a signed accumulator of width DATA_W+16 SHALL sum the N accepted samples, and data_out SHALL be the sum arithmetically shifted right by the effective dec_log2, truncated to DATA_W. The accumulator SHALL clear when the output is produced.
REQ-038 Macro undefined: no accumulator; data_out SHALL be the Nth accepted sample (pick-every-Nth).

Verification
REQ-039 AVG_EN, sel=1, dec_log2=2, frame_len=2; source 1 valid with samples 4,8,-4,12,1,1,1,1 -> data_out 5 then 1, done one cycle after the second strobe, sample_count 2.
REQ-040 No AVG_EN, same stimulus -> data_out 12 then 1.
REQ-041 sync_mode=1, src_sync[0] high at start -> stays ARMED; sync goes low then high -> RUN, and the sample in the edge cycle is counted.
REQ-042 frame_len=0, dec_log2=0, 10 valids with enable low on cycles 3-4 -> 8 outputs, busy stays high, no done.
REQ-043 Reset asserted after 1 of 2 frame outputs -> all outputs 0, state IDLE, no done pulse; a new start is accepted.
REQ-044 start pulsed while in RUN with different sel -> ignored, original source continues.

Source files
------------

// File: rtl/data_in_selector.sv
// Purpose : picks one of NUM_SRC sample streams and decimates it by 2^dec_log2 into framed output samples.
// Latency : data_out/data_out_valid register one cycle after the cycle that accepts the Nth sample.
// Backpr. : none; sources are strobe-only, enable low drops input samples and holds the FSM.
//
// Ports: clk/reset (sync, active-high); enable, start; sel, dec_log2, frame_len, sync_mode are
//        latched at start; src_data/src_valid/src_sync are the packed per-source inputs;
//        data_out/data_out_valid, busy (ARMED or RUN), done (frame-end pulse), sample_count.
// Option: define DATA_IN_SELECTOR_AVG_EN to output the average of each N-sample window
//         instead of the Nth sample.
module data_in_selector #(
  parameter int NUM_SRC = 4,
  parameter int DATA_W  = 32,
  parameter int SEL_W   = 2,
  parameter int FRAME_W = 32
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      enable,
  input  logic                      start,
  input  logic [SEL_W-1:0]          sel,
  input  logic [4:0]                dec_log2,
  input  logic [FRAME_W-1:0]        frame_len,
  input  logic                      sync_mode,
  input  logic [NUM_SRC*DATA_W-1:0] src_data,
  input  logic [NUM_SRC-1:0]        src_valid,
  input  logic [NUM_SRC-1:0]        src_sync,
  output logic [DATA_W-1:0]         data_out,
  output logic                      data_out_valid,
  output logic                      busy,
  output logic                      done,
  output logic [FRAME_W-1:0]        sample_count
);

  typedef enum logic [1:0] {S_IDLE, S_ARMED, S_RUN, S_DONE} state_t;

  state_t               state_q, state_d;
  logic [SEL_W-1:0]     sel_q, sel_d;
  logic [4:0]           dec_q, dec_d;
  logic [FRAME_W-1:0]   frame_len_q, frame_len_d;
  logic [15:0]          dec_cnt_q, dec_cnt_d;
  logic                 sync_q, sync_d;
  logic [DATA_W-1:0]    data_out_q, data_out_d;
  logic                 data_out_valid_q, data_out_valid_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic [FRAME_W-1:0]   sample_count_q, sample_count_d;

`ifdef DATA_IN_SELECTOR_AVG_EN
  localparam int ACC_W = DATA_W + 16;
  logic signed [ACC_W-1:0] acc_q, acc_d, acc_sum;
`endif

  logic [SEL_W-1:0]  sel_start;
  logic [4:0]        dec_start;
  logic [DATA_W-1:0] cur_data;
  logic              cur_valid, cur_sync, start_sync;
  logic [15:0]       dec_last;
  logic              frame_hit;
  logic              accept;

  // Out-of-range selects fall back to source 0; exponents above 16 saturate at 16.
  assign sel_start = (32'(sel) >= NUM_SRC) ? '0 : sel;
  assign dec_start = (dec_log2 > 5'd16) ? 5'd16 : dec_log2;

  // Terminal count N-1 as a mask: dec_q=0 gives 0, dec_q=16 gives 16'hFFFF.
  assign dec_last = 16'hFFFF >> (5'd16 - dec_q);

  // The output that just reached frame_len closes the frame; anything after it is dropped.
  assign frame_hit = data_out_valid_q && (frame_len_q != '0) && (sample_count_q == frame_len_q);

  // Source mux for the latched select, plus the sync level of the select being latched
  // so that a sync already high at start never reads as an edge.
  always_comb begin
    cur_data   = '0;
    cur_valid  = 1'b0;
    cur_sync   = 1'b0;
    start_sync = 1'b0;
    for (int k = 0; k < NUM_SRC; k++) begin
      if (sel_q == SEL_W'(k)) begin
        cur_data  = src_data[k*DATA_W +: DATA_W];
        cur_valid = src_valid[k];
        cur_sync  = src_sync[k];
      end
      if (sel_start == SEL_W'(k)) begin
        start_sync = src_sync[k];
      end
    end
  end

`ifdef DATA_IN_SELECTOR_AVG_EN
  assign acc_sum = acc_q + $signed({{16{cur_data[DATA_W-1]}}, cur_data});
`endif

  always_comb begin
    state_d          = state_q;
    sel_d            = sel_q;
    dec_d            = dec_q;
    frame_len_d      = frame_len_q;
    dec_cnt_d        = dec_cnt_q;
    sample_count_d   = sample_count_q;
    data_out_d       = data_out_q;
    data_out_valid_d = 1'b0;
    sync_d           = cur_sync;
    accept           = 1'b0;
`ifdef DATA_IN_SELECTOR_AVG_EN
    acc_d            = acc_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (start) begin
          sel_d          = sel_start;
          dec_d          = dec_start;
          frame_len_d    = frame_len;
          sample_count_d = '0;
          dec_cnt_d      = '0;
          sync_d         = start_sync;
`ifdef DATA_IN_SELECTOR_AVG_EN
          acc_d          = '0;
`endif
          state_d        = sync_mode ? S_ARMED : S_RUN;
        end
      end
      S_ARMED: begin
        // The edge cycle itself may carry the first sample.
        if (enable && cur_sync && !sync_q) begin
          state_d = S_RUN;
          accept  = cur_valid;
        end
      end
      S_RUN: begin
        // Frame close is not gated by enable: the last output has already been emitted.
        if (frame_hit) begin
          state_d = S_DONE;
        end else begin
          accept = enable && cur_valid;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (accept) begin
      if (dec_cnt_q == dec_last) begin
        dec_cnt_d        = '0;
        data_out_valid_d = 1'b1;
        sample_count_d   = sample_count_q + FRAME_W'(1);
`ifdef DATA_IN_SELECTOR_AVG_EN
        data_out_d       = DATA_W'(acc_sum >>> dec_q);
        acc_d            = '0;
`else
        data_out_d       = cur_data;
`endif
      end else begin
        dec_cnt_d = dec_cnt_q + 16'd1;
`ifdef DATA_IN_SELECTOR_AVG_EN
        acc_d     = acc_sum;
`endif
      end
    end

    busy_d = (state_d == S_ARMED) || (state_d == S_RUN);
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q          <= S_IDLE;
      sel_q            <= '0;
      dec_q            <= '0;
      frame_len_q      <= '0;
      dec_cnt_q        <= '0;
      sync_q           <= 1'b1;
      data_out_q       <= '0;
      data_out_valid_q <= 1'b0;
      busy_q           <= 1'b0;
      done_q           <= 1'b0;
      sample_count_q   <= '0;
`ifdef DATA_IN_SELECTOR_AVG_EN
      acc_q            <= '0;
`endif
    end else begin
      state_q          <= state_d;
      sel_q            <= sel_d;
      dec_q            <= dec_d;
      frame_len_q      <= frame_len_d;
      dec_cnt_q        <= dec_cnt_d;
      sync_q           <= sync_d;
      data_out_q       <= data_out_d;
      data_out_valid_q <= data_out_valid_d;
      busy_q           <= busy_d;
      done_q           <= done_d;
      sample_count_q   <= sample_count_d;
`ifdef DATA_IN_SELECTOR_AVG_EN
      acc_q            <= acc_d;
`endif
    end
  end

  assign data_out       = data_out_q;
  assign data_out_valid = data_out_valid_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign sample_count   = sample_count_q;

endmodule

// File: tb/tb_data_in_selector.sv
// Purpose : self-checking bench for data_in_selector against a sample-window reference model.
// Latency : the model predicts the outputs visible just after each rising edge.
// Backpr. : none; stimulus is strobe-only with random enable gaps.
module tb_data_in_selector;
  localparam int NUM_SRC = 3;
  localparam int DATA_W  = 16;
  localparam int SEL_W   = 2;
  localparam int FRAME_W = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                      reset, enable, start, sync_mode;
  logic [SEL_W-1:0]          sel;
  logic [4:0]                dec_log2;
  logic [FRAME_W-1:0]        frame_len;
  logic [NUM_SRC*DATA_W-1:0] src_data;
  logic [NUM_SRC-1:0]        src_valid, src_sync;
  logic [DATA_W-1:0]         data_out;
  logic                      data_out_valid, busy, done;
  logic [FRAME_W-1:0]        sample_count;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  data_in_selector #(
    .NUM_SRC(NUM_SRC), .DATA_W(DATA_W), .SEL_W(SEL_W), .FRAME_W(FRAME_W)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable), .start(start), .sel(sel),
    .dec_log2(dec_log2), .frame_len(frame_len), .sync_mode(sync_mode),
    .src_data(src_data), .src_valid(src_valid), .src_sync(src_sync),
    .data_out(data_out), .data_out_valid(data_out_valid), .busy(busy),
    .done(done), .sample_count(sample_count)
  );

  // ---------------- reference model ----------------
  // A frame is open from start until the output quota is met; accepted samples
  // collect in a window and every N of them yield one output.
  int  m_sel = 0, m_dec = 0, m_n = 1, m_len = 0;
  bit  m_open = 0, m_wait = 0, m_closing = 0, m_in_done = 0, m_sync_prev = 1;
  logic signed [DATA_W-1:0] m_win[$];
  logic signed [DATA_W-1:0] e_data = '0;
  logic [FRAME_W-1:0]       e_count = '0;
  logic                     e_valid = 0, e_busy = 0, e_done = 0;

  task automatic model_edge();
    bit take;
    bit s_now;
    longint sum;
    e_valid = 1'b0;
    if (reset) begin
      m_open = 0; m_wait = 0; m_closing = 0; m_in_done = 0; m_sync_prev = 1; m_sel = 0;
      m_win.delete();
      e_data = '0; e_busy = 0; e_done = 0; e_count = '0;
      return;
    end
    s_now  = src_sync[m_sel];
    e_done = 1'b0;
    if (m_in_done) begin
      m_in_done = 0;
    end else if (m_closing) begin
      m_closing = 0; m_open = 0; e_busy = 0; e_done = 1; m_in_done = 1;
    end else if (!m_open) begin
      if (start) begin
        m_sel  = (int'(sel) >= NUM_SRC) ? 0 : int'(sel);
        m_dec  = (dec_log2 > 16) ? 16 : int'(dec_log2);
        m_n    = 1 << m_dec;
        m_len  = int'(frame_len);
        m_wait = sync_mode;
        m_open = 1; e_busy = 1; e_count = '0;
        m_win.delete();
        s_now  = src_sync[m_sel];
      end
    end else begin
      take = 0;
      if (m_wait) begin
        if (enable && s_now && !m_sync_prev) begin
          m_wait = 0;
          take   = src_valid[m_sel];
        end
      end else begin
        take = enable && src_valid[m_sel];
      end
      if (take) begin
        m_win.push_back(src_data[m_sel*DATA_W +: DATA_W]);
        if (m_win.size() == m_n) begin
`ifdef DATA_IN_SELECTOR_AVG_EN
          sum = 0;
          foreach (m_win[i]) sum += longint'(m_win[i]);
          e_data = DATA_W'(sum >>> m_dec);
`else
          sum = 0;
          e_data = m_win[m_n-1];
`endif
          m_win.delete();
          e_valid = 1;
          e_count = e_count + 1'b1;
          if (m_len != 0 && int'(e_count) == m_len) m_closing = 1;
        end
      end
    end
    m_sync_prev = s_now;
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    cyc++;
  endtask

  task automatic set_src(input int k, input int v);
    src_data[k*DATA_W +: DATA_W] = DATA_W'(v);
  endtask

  task automatic idle_inputs();
    start = 0; enable = 1; src_valid = '0; src_sync = '0; sync_mode = 0;
  endtask

  task automatic do_start(input int s, input int d, input int len, input bit sm);
    sel = SEL_W'(s); dec_log2 = 5'(d); frame_len = FRAME_W'(len); sync_mode = sm; start = 1;
    tick();
    start = 0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1; idle_inputs(); src_data = '0; sel = '0; dec_log2 = '0; frame_len = '0;
    tick(); tick();
    n_vec++;
    if ({data_out, data_out_valid, busy, done, sample_count} !== '0) begin
      n_err++;
      $display("FAIL reset_state got dat=%0d vld=%0b busy=%0b done=%0b cnt=%0d, expected all 0",
               data_out, data_out_valid, busy, done, sample_count);
    end
    reset = 0;
    tick();
  endtask

  task automatic test_frame_vector();
    int vals[8] = '{4, 8, -4, 12, 1, 1, 1, 1};
    int got[$];
    int got_cyc[$];
    int cnt_last = -1;
    int done_at = -1;
    int exp0;
`ifdef DATA_IN_SELECTOR_AVG_EN
    exp0 = 5;
`else
    exp0 = 12;
`endif
    idle_inputs();
    do_start(1, 2, 2, 0);
    for (int i = 0; i < 14; i++) begin
      if (i < 8) begin
        src_valid = 3'b011; set_src(1, vals[i]); set_src(0, -100);
      end else begin
        src_valid = '0;
      end
      tick();
      n_vec++;
      if ({busy, done, data_out_valid, sample_count, data_out} !== {e_busy, e_done, e_valid, e_count, e_data}) begin
        n_err++;
        $display("FAIL frame_model cyc=%0d got b=%0b d=%0b v=%0b cnt=%0d dat=%0d, expected %0b %0b %0b %0d %0d",
                 cyc, busy, done, data_out_valid, sample_count, $signed(data_out), e_busy, e_done, e_valid, e_count, e_data);
      end
      if (data_out_valid) begin
        got.push_back(int'($signed(data_out))); got_cyc.push_back(i); cnt_last = int'(sample_count);
      end
      if (done && done_at < 0) done_at = i;
    end
    n_vec++;
    if (got.size() != 2) begin
      n_err++; $display("FAIL frame_strobes got %0d strobes, expected 2", got.size());
    end else begin
      n_vec += 3;
      if (got[0] != exp0) begin n_err++; $display("FAIL frame_first got %0d, expected %0d", got[0], exp0); end
      if (got[1] != 1) begin n_err++; $display("FAIL frame_second got %0d, expected 1", got[1]); end
      if (done_at != got_cyc[1] + 1) begin
        n_err++; $display("FAIL frame_done_time got cycle %0d, expected %0d", done_at, got_cyc[1] + 1);
      end
    end
    n_vec++;
    if (cnt_last != 2) begin n_err++; $display("FAIL frame_count got %0d, expected 2", cnt_last); end
  endtask

  task automatic test_sync_arm();
    bit sync_seq[7] = '{1, 1, 1, 0, 1, 1, 1};
    int dat_seq[7]  = '{50, 51, 52, 53, 77, 78, 79};
    int got[$];
    idle_inputs();
    src_sync = 3'b001;
    do_start(0, 0, 2, 1);
    for (int i = 0; i < 10; i++) begin
      if (i < 7) begin
        src_sync = {2'b00, sync_seq[i]}; src_valid = 3'b001; set_src(0, dat_seq[i]);
      end else begin
        src_valid = '0;
      end
      tick();
      n_vec++;
      if ({busy, done, data_out_valid, sample_count, data_out} !== {e_busy, e_done, e_valid, e_count, e_data}) begin
        n_err++;
        $display("FAIL sync_model cyc=%0d got b=%0b d=%0b v=%0b cnt=%0d dat=%0d, expected %0b %0b %0b %0d %0d",
                 cyc, busy, done, data_out_valid, sample_count, $signed(data_out), e_busy, e_done, e_valid, e_count, e_data);
      end
      if (data_out_valid) got.push_back(int'($signed(data_out)));
      if (i == 3) begin
        n_vec++;
        if (busy !== 1'b1 || got.size() != 0) begin
          n_err++; $display("FAIL sync_armed got busy=%0b strobes=%0d, expected busy=1 strobes=0", busy, got.size());
        end
      end
    end
    n_vec++;
    if (got.size() != 2 || got[0] != 77 || got[1] != 78) begin
      n_err++; $display("FAIL sync_edge_sample got %0d strobes first=%0d, expected 2 strobes 77,78",
                        got.size(), (got.size() > 0) ? got[0] : -1);
    end
  endtask

  task automatic test_continuous();
    int strobes = 0;
    bit saw_done = 0;
    bit busy_drop = 0;
    idle_inputs();
    do_start(2, 0, 0, 0);
    for (int i = 0; i < 272; i++) begin
      src_valid = (i < 10 || (i >= 12 && i < 272)) ? 3'b100 : 3'b000;
      enable    = !(i == 2 || i == 3);
      set_src(2, i + 1);
      tick();
      n_vec++;
      if ({busy, done, data_out_valid, sample_count, data_out} !== {e_busy, e_done, e_valid, e_count, e_data}) begin
        n_err++;
        $display("FAIL cont_model cyc=%0d got b=%0b d=%0b v=%0b cnt=%0d dat=%0d, expected %0b %0b %0b %0d %0d",
                 cyc, busy, done, data_out_valid, sample_count, $signed(data_out), e_busy, e_done, e_valid, e_count, e_data);
      end
      if (data_out_valid) strobes++;
      if (done) saw_done = 1;
      if (!busy) busy_drop = 1;
      if (i == 11) begin
        n_vec++;
        if (strobes != 8 || busy_drop || saw_done) begin
          n_err++; $display("FAIL cont_ten got strobes=%0d busy_drop=%0b done=%0b, expected 8 0 0", strobes, busy_drop, saw_done);
        end
      end
    end
    n_vec++;
    if (sample_count !== FRAME_W'(12)) begin
      n_err++; $display("FAIL cont_wrap got cnt=%0d, expected 12", sample_count);
    end
    reset = 1; idle_inputs(); tick(); reset = 0; tick();
  endtask

  task automatic test_reset_mid_frame();
    bit saw_done = 0;
    idle_inputs();
    do_start(0, 1, 2, 0);
    src_valid = 3'b001; set_src(0, 9); tick(); set_src(0, 7); tick(); src_valid = '0; tick();
    n_vec++;
    if (sample_count !== FRAME_W'(1) || busy !== 1'b1) begin
      n_err++; $display("FAIL rst_mid_pre got cnt=%0d busy=%0b, expected 1 1", sample_count, busy);
    end
    reset = 1; tick(); reset = 0;
    n_vec++;
    if ({data_out, data_out_valid, busy, done, sample_count} !== '0) begin
      n_err++; $display("FAIL rst_mid_outputs got dat=%0d vld=%0b busy=%0b done=%0b cnt=%0d, expected all 0",
                        data_out, data_out_valid, busy, done, sample_count);
    end
    for (int i = 0; i < 4; i++) begin tick(); if (done) saw_done = 1; end
    n_vec++;
    if (saw_done) begin n_err++; $display("FAIL rst_mid_done got done=1, expected 0"); end
    do_start(1, 0, 1, 0);
    n_vec++;
    if (busy !== 1'b1) begin n_err++; $display("FAIL rst_mid_restart got busy=%0b, expected 1", busy); end
    src_valid = 3'b010; set_src(1, -3); tick(); src_valid = '0;
    n_vec++;
    if (data_out_valid !== 1'b1 || $signed(data_out) != -3) begin
      n_err++; $display("FAIL rst_mid_newframe got vld=%0b dat=%0d, expected 1 -3", data_out_valid, $signed(data_out));
    end
    tick(); tick(); tick();
  endtask

  task automatic test_start_ignored();
    int got[$];
    idle_inputs();
    do_start(0, 0, 4, 0);
    for (int i = 0; i < 9; i++) begin
      start = 0; src_valid = '0;
      set_src(1, 999);
      case (i)
        0: begin src_valid = 3'b001; set_src(0, 10); end
        1: begin src_valid = 3'b001; set_src(0, 11); end
        2: begin src_valid = 3'b011; set_src(0, 12); start = 1; sel = 2'd1; end
        3, 4: src_valid = 3'b010;
        5: begin src_valid = 3'b001; set_src(0, 13); end
        default: ;
      endcase
      tick();
      n_vec++;
      if ({busy, done, data_out_valid, sample_count, data_out} !== {e_busy, e_done, e_valid, e_count, e_data}) begin
        n_err++;
        $display("FAIL startign_model cyc=%0d got b=%0b d=%0b v=%0b cnt=%0d dat=%0d, expected %0b %0b %0b %0d %0d",
                 cyc, busy, done, data_out_valid, sample_count, $signed(data_out), e_busy, e_done, e_valid, e_count, e_data);
      end
      if (data_out_valid) got.push_back(int'($signed(data_out)));
    end
    start = 0;
    n_vec++;
    if (got.size() != 4 || got[0] != 10 || got[1] != 11 || got[2] != 12 || got[3] != 13) begin
      n_err++; $display("FAIL start_ignored got %0d strobes last=%0d, expected 10,11,12,13",
                        got.size(), (got.size() > 0) ? got[got.size()-1] : -1);
    end
  endtask

  task automatic test_random();
    int budget;
    for (int f = 0; f < 40; f++) begin
      idle_inputs();
      do_start($urandom_range(0, 3), $urandom_range(0, 2), $urandom_range(1, 3), 1'($urandom_range(0, 1)));
      budget = 400;
      while ((m_open || m_in_done) && budget > 0) begin
        budget--;
        enable    = ($urandom_range(0, 3) != 0);
        src_valid = NUM_SRC'($urandom);
        if ($urandom_range(0, 3) == 0) src_sync = NUM_SRC'($urandom);
        for (int k = 0; k < NUM_SRC; k++) set_src(k, int'($urandom_range(0, 65535)) - 32768);
        start = ($urandom_range(0, 15) == 0);
        sel   = SEL_W'($urandom);
        tick();
        n_vec++;
        if ({busy, done, data_out_valid, sample_count, data_out} !== {e_busy, e_done, e_valid, e_count, e_data}) begin
          n_err++;
          $display("FAIL rand_model frame=%0d cyc=%0d got b=%0b d=%0b v=%0b cnt=%0d dat=%0d, expected %0b %0b %0b %0d %0d",
                   f, cyc, busy, done, data_out_valid, sample_count, $signed(data_out), e_busy, e_done, e_valid, e_count, e_data);
        end
      end
      if (budget == 0) begin
        n_vec++; n_err++;
        $display("FAIL rand_timeout frame=%0d got frame still open, expected completion", f);
        reset = 1; idle_inputs(); tick(); reset = 0;
      end
    end
    idle_inputs();
  endtask

  initial begin
    reset = 1; enable = 1; start = 0; sync_mode = 0; sel = '0; dec_log2 = '0; frame_len = '0;
    src_data = '0; src_valid = '0; src_sync = '0;
    test_reset();
    test_frame_vector();
    test_sync_arm();
    test_continuous();
    test_reset_mid_frame();
    test_start_ignored();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
